climate_controller: RTL and testbench
=====================================

# climate_controller

Multi-zone successor to the single-zone heater/cooler controller: one hysteresis state machine (IDLE / HEATING / COOLING) per zone, parametrised in temperature width, thresholds and zone count. Adds a per-zone minimum-dwell timer for actuator protection and a shared power budget that caps how many zones run at once. Sits between the zone temperature sensors and the heater/cooler drive outputs.

## Interface
- WIDTH, 5: temperature bits per zone, unsigned
- ZONES, 2: number of independent zones
- HEAT_ON, 18: IDLE→HEATING when temp ≤ HEAT_ON
- TARGET, 20: HEATING→IDLE when temp ≥ TARGET; COOLING→IDLE when temp ≤ TARGET
- COOL_ON, 22: IDLE→COOLING when temp ≥ COOL_ON
- MIN_DWELL, 4: minimum cycles in a state before leaving it (≥1)
- MAX_ACTIVE, 1: max zones simultaneously HEATING or COOLING (1..ZONES)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  high = normal operation; low = force all zones to IDLE
- temperature  in  ZONES*WIDTH  zone z at bits [z*WIDTH +: WIDTH]
- heating  out  ZONES  bit z high while zone z is HEATING
- cooling  out  ZONES  bit z high while zone z is COOLING
- waiting  out  ZONES  bit z high while zone z wants to activate but is refused for budget

## Operation
- Required: HEAT_ON < TARGET < COOL_ON, all representable in WIDTH; compare unsigned.
- Per-zone states: IDLE (00), HEATING (10), COOLING (01) as {heating,cooling}; 11 never driven.
- Transitions (only when the zone's dwell counter is 0):
  - IDLE: temp ≤ HEAT_ON → request HEATING; temp ≥ COOL_ON → request COOLING; else stay.
  - HEATING: temp ≥ TARGET → IDLE; else stay.
  - COOLING: temp ≤ TARGET → IDLE; else stay.
  - No direct HEATING↔COOLING path; always at least one cycle in IDLE.
- Dwell: on every state change the zone's counter loads MIN_DWELL-1 and decrements to 0 once per cycle; holding state leaves it at 0.
- Budget: active count = zones currently HEATING/COOLING (registered). IDLE requests are granted in ascending zone index while active count + earlier grants this cycle < MAX_ACTIVE. Zones returning to IDLE this cycle free budget only from the next cycle.
- Refused request: zone stays IDLE, waiting[z]=1; waiting clears when granted or when the request goes away.
- enable low: every zone goes to IDLE at next edge regardless of dwell; counters cleared to 0; waiting cleared; while low, no requests.

## Timing
- Reset (asynchronous, rst_n low): all zones IDLE, heating=0, cooling=0, waiting=0, counters 0 (eligible immediately after release).
- temperature sampled on rising clk; state and outputs updated on that edge; one-edge latency, all outputs registered.
- Refusal: waiting asserts at the same edge the grant would have occurred.
- Cooling→heating at MIN_DWELL=1: minimum two edges (COOLING→IDLE, IDLE→HEATING).
- enable/rst_n mid-dwell: dwell is abandoned; no partial state retained.

## Configuration
- CLIMATE_MIN_DWELL_EN defined: dwell counters built as above.
- Undefined: no counters; every zone eligible to transition every cycle (equivalent to MIN_DWELL=1); MIN_DWELL ignored.

## Test plan
- Single-zone hysteresis (ZONES=1, MAX_ACTIVE=1, MIN_DWELL=1): temp 0,18,19,20,22,21,20,21,19,18 → states H,H,H,I,C,C,I,I,I,H.
- No direct path: zone in COOLING at 25, step temp to 15 → IDLE after 1 edge, HEATING after 2nd edge; reverse 15→25 likewise.
- Dwell (MIN_DWELL=4, macro defined): zone enters HEATING at 15, temp set 25 next cycle → stays HEATING 3 more edges, IDLE on 4th; with macro undefined, IDLE on 1st.
- Budget (ZONES=2, MAX_ACTIVE=1): both zones at 15 same cycle → zone0 HEATING, zone1 waiting=1; zone0 temp to 20 → zone0 IDLE, zone1 HEATING one edge later, waiting clears.
- enable low during HEATING with dwell pending → all heating/cooling/waiting 0 at next edge; re-enable with temp 15 → HEATING next edge.
- rst_n asserted mid-COOLING between edges → outputs 0 immediately; release with temp 25 → COOLING after first edge.

Source files
------------

// File: rtl/climate_controller.sv
// Multi-zone heater/cooler controller: per-zone IDLE/HEATING/COOLING hysteresis FSM,
// shared power budget, optional per-zone minimum dwell (macro CLIMATE_MIN_DWELL_EN).
module climate_controller #(
  parameter int WIDTH      = 5,
  parameter int ZONES      = 2,
  parameter int HEAT_ON    = 18,
  parameter int TARGET     = 20,
  parameter int COOL_ON    = 22,
  parameter int MIN_DWELL  = 4,
  parameter int MAX_ACTIVE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [ZONES*WIDTH-1:0] temperature,
  output logic [ZONES-1:0]       heating,
  output logic [ZONES-1:0]       cooling,
  output logic [ZONES-1:0]       waiting
);

  // Encoding matches {heating, cooling}; 2'b11 is never produced.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COOLING = 2'b01,
    ST_HEATING = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] L_HEAT_ON = WIDTH'(HEAT_ON);
  localparam logic [WIDTH-1:0] L_TARGET  = WIDTH'(TARGET);
  localparam logic [WIDTH-1:0] L_COOL_ON = WIDTH'(COOL_ON);

  state_t           r_state [ZONES];
  state_t           w_next  [ZONES];
  logic [ZONES-1:0] r_heating;
  logic [ZONES-1:0] r_cooling;
  logic [ZONES-1:0] r_waiting;
  logic [ZONES-1:0] w_wait;
  logic [ZONES-1:0] w_eligible;
  logic [WIDTH-1:0] w_temp;
  state_t           w_req;
  int               w_active;
  int               w_grants;

`ifdef CLIMATE_MIN_DWELL_EN
  localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [DW_W-1:0] L_DWELL_LOAD = DW_W'(MIN_DWELL - 1);

  logic [DW_W-1:0] r_dwell [ZONES];

  always_comb begin
    w_eligible = '0;
    for (int z = 0; z < ZONES; z++) begin
      w_eligible[z] = (r_dwell[z] == '0);
    end
  end

  // Disable or reset abandons any pending dwell so zones are eligible at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < ZONES; z++) r_dwell[z] <= '0;
    end else if (!enable) begin
      for (int z = 0; z < ZONES; z++) r_dwell[z] <= '0;
    end else begin
      for (int z = 0; z < ZONES; z++) begin
        if (w_next[z] != r_state[z]) begin
          r_dwell[z] <= L_DWELL_LOAD;
        end else if (r_dwell[z] != '0) begin
          r_dwell[z] <= r_dwell[z] - 1'b1;
        end
      end
    end
  end
`else
  assign w_eligible = '1;
`endif

  // Next-state and budget arbitration; budget counts registered states only, so a
  // zone dropping to IDLE this cycle frees its slot from the next cycle.
  always_comb begin
    w_active = 0;
    w_grants = 0;
    w_temp   = '0;
    w_req    = ST_IDLE;
    w_wait   = '0;
    for (int z = 0; z < ZONES; z++) begin
      w_next[z] = r_state[z];
      if (r_state[z] != ST_IDLE) w_active = w_active + 1;
    end
    for (int z = 0; z < ZONES; z++) begin
      w_temp = temperature[z*WIDTH +: WIDTH];
      w_req  = ST_IDLE;
      if (enable && w_eligible[z]) begin
        case (r_state[z])
          ST_IDLE: begin
            if (w_temp <= L_HEAT_ON)      w_req = ST_HEATING;
            else if (w_temp >= L_COOL_ON) w_req = ST_COOLING;
            if (w_req != ST_IDLE) begin
              if (w_active + w_grants < MAX_ACTIVE) begin
                w_next[z] = w_req;
                w_grants  = w_grants + 1;
              end else begin
                w_wait[z] = 1'b1;
              end
            end
          end
          ST_HEATING: if (w_temp >= L_TARGET) w_next[z] = ST_IDLE;
          ST_COOLING: if (w_temp <= L_TARGET) w_next[z] = ST_IDLE;
          default:    w_next[z] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < ZONES; z++) r_state[z] <= ST_IDLE;
      r_heating <= '0;
      r_cooling <= '0;
      r_waiting <= '0;
    end else if (!enable) begin
      for (int z = 0; z < ZONES; z++) r_state[z] <= ST_IDLE;
      r_heating <= '0;
      r_cooling <= '0;
      r_waiting <= '0;
    end else begin
      for (int z = 0; z < ZONES; z++) begin
        r_state[z]   <= w_next[z];
        r_heating[z] <= (w_next[z] == ST_HEATING);
        r_cooling[z] <= (w_next[z] == ST_COOLING);
      end
      r_waiting <= w_wait;
    end
  end

  assign heating = r_heating;
  assign cooling = r_cooling;
  assign waiting = r_waiting;

endmodule

// File: tb/tb_climate_controller.sv
// Directed bench for climate_controller: single-zone hysteresis table plus
// two-zone dwell, budget, enable and reset sequences.
module tb_climate_controller;

`ifdef CLIMATE_MIN_DWELL_EN
  localparam int DW = 4;
`else
  localparam int DW = 1;
`endif

  logic       clk;
  logic       rst_n_a, enable_a;
  logic [4:0] temp_a;
  logic [0:0] heat_a, cool_a, wait_a;
  logic       rst_n_b, enable_b;
  logic [9:0] temp_b;
  logic [1:0] heat_b, cool_b, wait_b;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [4:0] temp;
    logic       exp_h;
    logic       exp_c;
  } vec_t;
  vec_t vecs [10];

  climate_controller #(
    .WIDTH(5), .ZONES(1), .HEAT_ON(18), .TARGET(20), .COOL_ON(22),
    .MIN_DWELL(1), .MAX_ACTIVE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(enable_a), .temperature(temp_a),
    .heating(heat_a), .cooling(cool_a), .waiting(wait_a)
  );

  climate_controller #(
    .WIDTH(5), .ZONES(2), .HEAT_ON(18), .TARGET(20), .COOL_ON(22),
    .MIN_DWELL(4), .MAX_ACTIVE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .temperature(temp_b),
    .heating(heat_b), .cooling(cool_b), .waiting(wait_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic [1:0] h, input logic [1:0] c,
                         input logic [1:0] w);
    check({name, ".heat"}, {6'd0, heat_b}, {6'd0, h});
    check({name, ".cool"}, {6'd0, cool_b}, {6'd0, c});
    check({name, ".wait"}, {6'd0, wait_b}, {6'd0, w});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{5'd0,  1'b1, 1'b0};
    vecs[1] = '{5'd18, 1'b1, 1'b0};
    vecs[2] = '{5'd19, 1'b1, 1'b0};
    vecs[3] = '{5'd20, 1'b0, 1'b0};
    vecs[4] = '{5'd22, 1'b0, 1'b1};
    vecs[5] = '{5'd21, 1'b0, 1'b1};
    vecs[6] = '{5'd20, 1'b0, 1'b0};
    vecs[7] = '{5'd21, 1'b0, 1'b0};
    vecs[8] = '{5'd19, 1'b0, 1'b0};
    vecs[9] = '{5'd18, 1'b1, 1'b0};

    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    temp_a   = 5'd0;
    temp_b   = {5'd20, 5'd20};
    #2;
    check("reset_a.heat", {7'd0, heat_a}, 8'd0);
    check("reset_a.cool", {7'd0, cool_a}, 8'd0);
    check("reset_a.wait", {7'd0, wait_a}, 8'd0);
    check_b("reset_b", 2'b00, 2'b00, 2'b00);
    #10;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // single-zone hysteresis table
    for (int i = 0; i < 10; i++) begin
      temp_a = vecs[i].temp;
      tick();
      check($sformatf("hyst[%0d].heat", i), {7'd0, heat_a}, {7'd0, vecs[i].exp_h});
      check($sformatf("hyst[%0d].cool", i), {7'd0, cool_a}, {7'd0, vecs[i].exp_c});
      check($sformatf("hyst[%0d].wait", i), {7'd0, wait_a}, 8'd0);
    end

    // heating -> cooling must pass through IDLE, and back
    temp_a = 5'd25;
    tick();
    check("h2c_step1", {6'd0, heat_a, cool_a}, 8'b00);
    tick();
    check("h2c_step2", {6'd0, heat_a, cool_a}, 8'b01);
    temp_a = 5'd15;
    tick();
    check("c2h_step1", {6'd0, heat_a, cool_a}, 8'b00);
    tick();
    check("c2h_step2", {6'd0, heat_a, cool_a}, 8'b10);

    // dwell: zone0 heats, then overheats; leaves only once dwell expires
    temp_b = {5'd20, 5'd15};
    tick();
    check_b("dwell_enter", 2'b01, 2'b00, 2'b00);
    temp_b = {5'd20, 5'd25};
    for (int i = 0; i < DW - 1; i++) begin
      tick();
      check_b($sformatf("dwell_hold[%0d]", i), 2'b01, 2'b00, 2'b00);
    end
    tick();
    check_b("dwell_exit", 2'b00, 2'b00, 2'b00);
    temp_b = {5'd20, 5'd20};
    for (int i = 0; i < DW; i++) tick();
    check_b("dwell_settle", 2'b00, 2'b00, 2'b00);

    // budget: one slot, zone0 wins, zone1 waits until slot frees next cycle
    temp_b = {5'd15, 5'd15};
    tick();
    check_b("budget_grant", 2'b01, 2'b00, 2'b10);
    temp_b = {5'd15, 5'd20};
    for (int i = 0; i < DW - 1; i++) begin
      tick();
      check_b($sformatf("budget_hold[%0d]", i), 2'b01, 2'b00, 2'b10);
    end
    tick();
    check_b("budget_release", 2'b00, 2'b00, 2'b10);
    tick();
    check_b("budget_handoff", 2'b10, 2'b00, 2'b00);

    // enable low with zone1 mid-dwell
    temp_b   = {5'd15, 5'd15};
    enable_b = 1'b0;
    tick();
    check_b("disable_edge", 2'b00, 2'b00, 2'b00);
    tick();
    check_b("disable_hold", 2'b00, 2'b00, 2'b00);
    enable_b = 1'b1;
    tick();
    check_b("reenable", 2'b01, 2'b00, 2'b10);

    // asynchronous reset mid-COOLING
    enable_b = 1'b0;
    tick();
    temp_b   = {5'd20, 5'd25};
    enable_b = 1'b1;
    tick();
    check_b("cool_before_rst", 2'b00, 2'b01, 2'b00);
    #2;
    rst_n_b = 1'b0;
    #1;
    check_b("async_rst", 2'b00, 2'b00, 2'b00);
    #2;
    rst_n_b = 1'b1;
    tick();
    check_b("after_rst", 2'b00, 2'b01, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
